csr_unit: RTL
=============

# csr_unit

Parametrised machine-mode CSR unit, successor to the single-register `csr` block. It decodes the upper instruction field, executes all six Zicsr operations (register and immediate forms), and holds `NUM_SCRATCH` general read/write CSRs plus optional 64-bit `mcycle`/`minstret` counters. It flags illegal accesses. It sits beside the register file in the execute stage: `rd` returns the old CSR value to the writeback mux, and all updates commit on the next rising clock edge.

## Interface
- `XLEN`, 32: data width; only 32 or 64 are legal values.
- `NUM_SCRATCH`, 4: number of scratch CSRs, 1..16, mapped at `0x7C0 + i`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `we`  in  1  instruction valid; a CSR access is performed only when this is high.
- `instr_31_12`  in  20  instruction bits [31:12]: `[19:8]` = CSR address, `[7:3]` = rs1 index / uimm, `[2:0]` = funct3.
- `wd`  in  XLEN  rs1 value, used by the register forms.
- `retire`  in  1  instruction-retired pulse; increments `minstret`.
- `rd`  out  XLEN  old value of the addressed CSR; combinational; 0 when the access is illegal.
- `illegal`  out  1  combinational; high when `we` is high and the access is illegal.

## Operation
- Operand selection: if funct3[2] = 1, the operand is the zero-extended 5-bit uimm; otherwise the operand is `wd`.
- New value by operation:
  - rw / rwi (funct3 001 / 101): new = operand.
  - rs / rsi (funct3 010 / 110): new = old | operand.
  - rc / rci (funct3 011 / 111): new = old & ~operand.
- Write enable = `we` & !`illegal` & (funct3[1:0]==01 | src field != 0). The src field is `[7:3]`. Set/clear operations with rs1 = x0 or uimm = 0 never write, even to read-only CSRs.
- `illegal` is asserted when `we` is high and any of these holds:
  - funct3 is 000 or 100;
  - the address is unimplemented;
  - a write would occur (per the rule above, ignoring `illegal`) and address[11:10] = 11 (read-only space).
- Address map:
  - Scratch CSRs at `0x7C0..0x7C0+NUM_SCRATCH-1`, read/write.
  - Counters (macro-gated): `mcycle` 0xB00, `minstret` 0xB02, `mcycleh` 0xB80, `minstreth` 0xB82, all read/write.
  - Read-only shadows: `cycle` 0xC00, `instret` 0xC02, `cycleh` 0xC80, `instreth` 0xC82.
  - With XLEN = 64, all `*h` addresses are unimplemented and the low address reads or writes the full 64 bits.
- Counters are 64-bit.
  - `mcycle` increments by 1 every cycle while `rst_n` is high.
  - `minstret` increments by 1 in each cycle where `retire` is high.
  - Both wrap from 2^64−1 to 0.
  - Carry propagates from the low half into the high half.
- When a write and an increment hit the same counter in the same cycle, the write wins. That cycle's increment is dropped. A write to one half leaves the other half unchanged in that cycle, with no carry from the dropped increment. Counting resumes from the written value in the next cycle.

## Timing
- Reset: when `rst_n` = 0 at a rising edge, all scratch CSRs and counters become 0. Reset overrides any write or increment in that cycle. `rd` then reads 0 for any legal address.
- Read latency 0: `rd` reflects the register state before the current edge. Read-modify-write completes in one cycle.
- Write latency 1: the new value is visible on `rd` in the cycle after the write.
- Back-to-back accesses to the same CSR see each other's results with no stall or bypass hazard.
- `mcycle` reads 0 in the first cycle after reset is released, then 1, 2, ...

## Configuration
- `CSR_COUNTERS_EN` defined: counter registers, increment logic and addresses 0xB00/0xB02/0xB80/0xB82/0xC00/0xC02/0xC80/0xC82 are present. `retire` is used.
- `CSR_COUNTERS_EN` undefined: no counter storage. Those addresses are unimplemented, so any access raises `illegal` and `rd` returns 0. `retire` is ignored.

## Test plan
- csrrw 0x7C0 with `wd`=0x0000_0003, then csrrs 0x7C0 with `wd`=0xFFFF_FFFF, then csrrc 0x7C0 with `wd`=0xFFFF_FFFF -> `rd` = 0, then 3, then 0xFFFF_FFFF; final register value 0.
- csrrwi 0x7C1 uimm=5, csrrsi uimm=0x18, csrrci uimm=1 -> `rd` = 0, 5, 0x1D; final value 0x1C.
- csrrs 0xC00 with rs1=x0 -> `illegal`=0, `rd`=cycle count. csrrw 0xC00 -> `illegal`=1, `rd`=0, no state change. funct3=100 -> `illegal`=1. Address 0x7C0+NUM_SCRATCH -> `illegal`=1.
- Write `mcycle`=0xFFFF_FFFF, then read `mcycleh`/`mcycle` over the next cycles -> carry into the high half gives `mcycleh`=1, `mcycle`=0 exactly two cycles after the write.
- `retire` high for 3 cycles while csrrw `minstret`=10 in the middle cycle -> `minstret` reads 10, then 11 after the third `retire` cycle.
- Assert `rst_n`=0 during a write cycle to 0x7C0 -> value stays 0. Build without `CSR_COUNTERS_EN` and read 0xB00 -> `illegal`=1.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: machine-mode Zicsr unit with NUM_SCRATCH scratch CSRs at 0x7C0+i.
// Define CSR_COUNTERS_EN to add 64-bit mcycle/minstret and their read-only shadows.
module csr_unit #(
  parameter int XLEN        = 32,
  parameter int NUM_SCRATCH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [19:0]     instr_31_12,
  input  logic [XLEN-1:0] wd,
  input  logic            retire,
  output logic [XLEN-1:0] rd,
  output logic            illegal
);
  logic [11:0]     addr;
  logic [4:0]      src;
  logic [2:0]      f3;
  logic [XLEN-1:0] scratch [NUM_SCRATCH];
  logic [XLEN-1:0] opnd, old, nv, scr_rd, cnt_rd;
  logic            scr_hit, cnt_hit, wr_req, wen;
  assign {addr, src, f3} = instr_31_12;
  assign scr_hit = addr[11:4] == 8'h7C && {1'b0, addr[3:0]} < 5'(NUM_SCRATCH);
  always_comb begin
    scr_rd = '0;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (addr[3:0] == 4'(i)) scr_rd = scratch[i];
  end
  assign old  = scr_hit ? scr_rd : cnt_rd;
  assign opnd = f3[2] ? XLEN'(src) : wd;
  assign nv   = !f3[1] ? opnd : f3[0] ? old & ~opnd : old | opnd;
  // Set/clear with a zero source is a pure read, so it is legal even on read-only CSRs.
  assign wr_req  = we & (f3[1:0] == 2'b01 | src != 5'd0);
  assign illegal = we & (f3[1:0] == 2'b00 | !(scr_hit | cnt_hit) | (wr_req & addr[11:10] == 2'b11));
  assign wen     = wr_req & !illegal;
  assign rd      = illegal ? '0 : old;
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (!rst_n) scratch[i] <= '0;
      else if (wen && scr_hit && addr[3:0] == 4'(i)) scratch[i] <= nv;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret, cnt, cnt_wv;
  logic        cnt_hi;
  assign cnt_hi  = addr[7];
  assign cnt_hit = (addr[11:8] == 4'hB || addr[11:8] == 4'hC) && addr[6:2] == 5'd0 && !addr[0]
                   && (!cnt_hi || XLEN == 32);
  assign cnt     = addr[1] ? minstret : mcycle;
  assign cnt_rd  = cnt_hit ? (cnt_hi ? XLEN'(cnt[63:32]) : cnt[XLEN-1:0]) : '0;
  // A half-write keeps the other half's pre-edge value; the dropped increment never carries.
  assign cnt_wv  = cnt_hi ? {nv[31:0], cnt[31:0]} : XLEN == 64 ? 64'(nv) : {cnt[63:32], nv[31:0]};
  always_ff @(posedge clk)
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= wen && cnt_hit && !addr[1] ? cnt_wv : mcycle + 64'd1;
      minstret <= wen && cnt_hit && addr[1] ? cnt_wv : minstret + 64'(retire);
    end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cnt_hit       = 1'b0;
  assign cnt_rd        = '0;
`endif
endmodule
